secded_scrub_ctrl: RTL and testbench

Controller for a small ECC-protected storage array built on the team's Hamming(7,4)+overall-parity SECDED code. It encodes host writes and decodes and corrects host reads, with correct-on-read write-back. A background scrubber walks the array periodically and writes back single-bit corrections. A host/scrub arbiter shares the single array port. An error-injection port flips stored bits so the bench can exercise the code.

---
 rtl/secded_pkg.sv | 35 +++
 rtl/secded84_codec.sv | 61 ++++++
 rtl/secded_scrub_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_secded_scrub_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// ============================================================================
// Module : secded_pkg
// Brief  : Shared types and constants for the Hamming(7,4)+parity SECDED controller
// Rev    : 1.0
// ============================================================================
`default_nettype none

package secded_pkg;

    localparam int c_cw_w = 8;
    localparam int c_dw   = 4;

    localparam int c_pos_d0 = 3;
    localparam int c_pos_d1 = 5;
    localparam int c_pos_d2 = 6;
    localparam int c_pos_d3 = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_H_RD  = 3'd1,
        ST_H_RSP = 3'd2,
        ST_S_RD  = 3'd3,
        ST_S_WB  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ONE  = 2'd1,
        ERR_PAR  = 2'd2,
        ERR_TWO  = 2'd3
    } err_e;

endpackage

`default_nettype wire

// File: rtl/secded84_codec.sv
// ============================================================================
// Module : secded84_codec
// Brief  : Combinational SECDED encoder (data -> codeword) and decoder/corrector
// Rev    : 1.0
// ============================================================================
`default_nettype none

module secded84_codec
    import secded_pkg::*;
(
    input  logic [c_dw-1:0]   i_data,
    input  logic [c_cw_w-1:0] i_cw,
    output logic [c_cw_w-1:0] o_enc_cw,
    output logic [c_dw-1:0]   o_dec_data,
    output logic [c_cw_w-1:0] o_dec_cw,
    output err_e              o_dec_err
);

    logic [6:0] w_ham;
    logic [2:0] w_syn;
    logic       w_pf;

    assign w_ham = {i_data[3], i_data[2], i_data[1],
                    i_data[1] ^ i_data[2] ^ i_data[3],
                    i_data[0],
                    i_data[0] ^ i_data[2] ^ i_data[3],
                    i_data[0] ^ i_data[1] ^ i_data[3]};
    assign o_enc_cw = {^w_ham, w_ham};

    // Syndrome is the XOR of the position numbers of every set Hamming bit.
    always_comb begin
        w_syn = '0;
        for (int k = 1; k < c_cw_w; k++) begin
            if (i_cw[k-1]) begin
                w_syn = w_syn ^ 3'(k);
            end
        end
    end

    assign w_pf = ^i_cw;

    always_comb begin
        o_dec_cw  = i_cw;
        o_dec_err = ERR_NONE;
        if (w_syn != 3'd0 && w_pf) begin
            o_dec_err                 = ERR_ONE;
            o_dec_cw[w_syn - 3'd1]    = ~i_cw[w_syn - 3'd1];
        end else if (w_syn == 3'd0 && w_pf) begin
            o_dec_err   = ERR_PAR;
            o_dec_cw[7] = ^i_cw[6:0];
        end else if (w_syn != 3'd0 && !w_pf) begin
            o_dec_err = ERR_TWO;
        end
    end

    assign o_dec_data = {o_dec_cw[c_pos_d3-1], o_dec_cw[c_pos_d2-1],
                         o_dec_cw[c_pos_d1-1], o_dec_cw[c_pos_d0-1]};

endmodule

`default_nettype wire

// File: rtl/secded_scrub_ctrl.sv
// ============================================================================
// Module : secded_scrub_ctrl
// Brief  : SECDED storage controller with correct-on-read, background scrub, injection
// Rev    : 1.0
// ============================================================================
`default_nettype none

module secded_scrub_ctrl
    import secded_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int AW             = $clog2(DEPTH),
    parameter int SCRUB_INTERVAL = 64,
    parameter int SCRUB_MAX_WAIT = 8,
    parameter int CNT_W          = 16
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [AW-1:0]     i_req_addr,
    input  logic [3:0]        i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [3:0]        o_rsp_data,
    output logic              o_rsp_1bit_error,
    output logic              o_rsp_parity_error,
    output logic              o_rsp_2bit_error,
    input  logic              i_inj_valid,
    input  logic [AW-1:0]     i_inj_addr,
    input  logic [7:0]        i_inj_mask,
    output logic              o_scrub_busy,
    output logic [CNT_W-1:0]  o_cnt_corr,
    output logic [CNT_W-1:0]  o_cnt_uncorr
);

    localparam int c_tmr_w  = $clog2(SCRUB_INTERVAL);
    localparam int c_wait_w = $clog2(SCRUB_MAX_WAIT + 1);
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(SCRUB_INTERVAL - 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(SCRUB_MAX_WAIT);

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         rd_q;
    logic [AW-1:0]      addr_q;
    logic [AW-1:0]      ptr_q;
    logic [7:0]         corr_q;
    err_e               err_q;
    logic [3:0]         data_q;
    logic               rsp_valid_q;
    logic               ready_q, ready_d;
    logic               busy_q;
    logic [c_tmr_w-1:0] tmr_q, tmr_d;
    logic               pend_q, pend_d;
    logic [c_wait_w-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_corr_q, cnt_uncorr_q;

    logic               w_accept, w_expire, w_scrub_done;
    logic               w_wr_en, w_inc_corr, w_inc_uncorr;
    logic [AW-1:0]      w_wr_addr;
    logic [7:0]         w_wr_cw;
    logic [7:0]         w_enc_cw, w_dec_cw;
    logic [3:0]         w_dec_data;
    err_e               w_dec_err;
    logic [3:0]         w_enc_unused_data;
    logic [7:0]         w_enc_unused_cw, w_dec_unused_cw;
    err_e               w_enc_unused_err;

    secded84_codec u_enc (
        .i_data     (i_req_wdata),
        .i_cw       (8'h00),
        .o_enc_cw   (w_enc_cw),
        .o_dec_data (w_enc_unused_data),
        .o_dec_cw   (w_enc_unused_cw),
        .o_dec_err  (w_enc_unused_err)
    );

    secded84_codec u_dec (
        .i_data     (4'h0),
        .i_cw       (rd_q),
        .o_enc_cw   (w_dec_unused_cw),
        .o_dec_data (w_dec_data),
        .o_dec_cw   (w_dec_cw),
        .o_dec_err  (w_dec_err)
    );

    assign w_accept = (state_q == ST_IDLE) && ready_q && i_req_valid;

    always_comb begin
        state_d      = state_q;
        w_wr_en      = 1'b0;
        w_wr_addr    = i_req_addr;
        w_wr_cw      = w_enc_cw;
        w_inc_corr   = 1'b0;
        w_inc_uncorr = 1'b0;
        w_scrub_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_wr_en = i_req_we;
                    state_d = i_req_we ? ST_IDLE : ST_H_RD;
                end else if (pend_q) begin
                    state_d = ST_S_RD;
                end
            end
            ST_H_RD: state_d = ST_H_RSP;
            ST_H_RSP: begin
                // Entry cycle (response not yet valid) performs the write-back.
                if (!rsp_valid_q) begin
                    w_wr_en      = (err_q == ERR_ONE) || (err_q == ERR_PAR);
                    w_wr_addr    = addr_q;
                    w_wr_cw      = corr_q;
                    w_inc_corr   = w_wr_en;
                    w_inc_uncorr = (err_q == ERR_TWO);
                end else if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_S_RD: state_d = ST_S_WB;
            ST_S_WB: begin
                w_wr_en      = (w_dec_err == ERR_ONE) || (w_dec_err == ERR_PAR);
                w_wr_addr    = ptr_q;
                w_wr_cw      = w_dec_cw;
                w_inc_corr   = w_wr_en;
                w_inc_uncorr = (w_dec_err == ERR_TWO);
                w_scrub_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_expire = (tmr_q == c_tmr_last);
        tmr_d    = w_expire ? '0 : tmr_q + 1'b1;
        pend_d   = w_scrub_done ? 1'b0 : (pend_q | w_expire);
        if (w_scrub_done) begin
            wait_d = '0;
        end else if (pend_q && (state_q inside {ST_IDLE, ST_H_RD, ST_H_RSP}) && wait_q < c_wait_max) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
        ready_d = (state_d == ST_IDLE) && (wait_d < c_wait_max);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_q         <= 8'h00;
            addr_q       <= '0;
            ptr_q        <= '0;
            corr_q       <= 8'h00;
            err_q        <= ERR_NONE;
            data_q       <= 4'h0;
            rsp_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            tmr_q        <= '0;
            pend_q       <= 1'b0;
            wait_q       <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= (state_d == ST_S_RD) || (state_d == ST_S_WB);
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;

            // Injection XORs on top of whatever is being stored this edge.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ((w_wr_en && w_wr_addr == AW'(i)) ? w_wr_cw : mem_q[i]) ^
                            ((i_inj_valid && i_inj_addr == AW'(i)) ? i_inj_mask : 8'h00);
            end

            if (w_accept && !i_req_we) begin
                rd_q   <= mem_q[i_req_addr];
                addr_q <= i_req_addr;
            end else if (state_q == ST_S_RD) begin
                rd_q <= mem_q[ptr_q];
            end

            if (state_q == ST_H_RD) begin
                data_q <= w_dec_data;
                err_q  <= w_dec_err;
                corr_q <= w_dec_cw;
            end

            if (state_q == ST_H_RSP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                end else if (i_rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end

            if (w_scrub_done) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (w_inc_corr && cnt_corr_q != '1) begin
                cnt_corr_q <= cnt_corr_q + 1'b1;
            end
            if (w_inc_uncorr && cnt_uncorr_q != '1) begin
                cnt_uncorr_q <= cnt_uncorr_q + 1'b1;
            end
        end
    end

    assign o_req_ready        = ready_q;
    assign o_rsp_valid        = rsp_valid_q;
    assign o_rsp_data         = data_q;
    assign o_rsp_1bit_error   = (err_q == ERR_ONE);
    assign o_rsp_parity_error = (err_q == ERR_PAR);
    assign o_rsp_2bit_error   = (err_q == ERR_TWO);
    assign o_scrub_busy       = busy_q;
    assign o_cnt_corr         = cnt_corr_q;
    assign o_cnt_uncorr       = cnt_uncorr_q;

endmodule

`default_nettype wire

// File: tb/tb_secded_scrub_ctrl.sv
// ============================================================================
// Module : tb_secded_scrub_ctrl
// Brief  : Scoreboard bench for secded_scrub_ctrl with directed vectors
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_secded_scrub_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SI    = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [3:0]       req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [3:0]       rsp_data;
    logic             rsp_e1, rsp_ep, rsp_e2;
    logic             inj_valid = 1'b0;
    logic [AW-1:0]    inj_addr = '0;
    logic [7:0]       inj_mask = '0;
    logic             scrub_busy;
    logic [CNT_W-1:0] cnt_corr, cnt_uncorr;

    secded_scrub_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .SCRUB_INTERVAL(SI), .SCRUB_MAX_WAIT(8), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_1bit_error(rsp_e1), .o_rsp_parity_error(rsp_ep), .o_rsp_2bit_error(rsp_e2),
        .i_inj_valid(inj_valid), .i_inj_addr(inj_addr), .i_inj_mask(inj_mask),
        .o_scrub_busy(scrub_busy), .o_cnt_corr(cnt_corr), .o_cnt_uncorr(cnt_uncorr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       e1;
        logic       ep;
        logic       e2;
        int         stamp;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   bw = 0;
    logic prev_v = 1'b0;
    logic prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tmo(input string name);
        n_chk++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Response monitor: compares every cycle the response is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    if (!prev_v) chk("rsp_latency", cyc - sb[0].stamp, 2);
                    chk("rsp_data", int'(rsp_data), int'(sb[0].data));
                    chk("rsp_1bit", int'(rsp_e1), int'(sb[0].e1));
                    chk("rsp_par",  int'(rsp_ep), int'(sb[0].ep));
                    chk("rsp_2bit", int'(rsp_e2), int'(sb[0].e2));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            prev_v = rsp_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b = 1'b0;
            bw     = 0;
        end else begin
            if (scrub_busy && !prev_b) begin
                pulses++;
                bw = 1;
            end else if (scrub_busy) begin
                bw++;
            end else if (prev_b) begin
                chk("busy_width", bw, 2);
            end
            prev_b = scrub_busy;
        end
    end

    task automatic req(input logic we, input logic [3:0] addr, input logic [3:0] wd,
                       input logic [3:0] ed, input logic e1, input logic ep, input logic e2);
        int   n;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                tmo("req_ready");
                break;
            end
        end
        if (req_ready) begin
            if (!we) begin
                e = '{ed, e1, ep, e2, cyc + 1};
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        req(1'b1, a, d, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] d,
                      input logic e1, input logic ep, input logic e2);
        req(1'b0, a, 4'h0, d, e1, ep, e2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) tmo("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [3:0] a, input logic [7:0] m);
        @(negedge clk);
        inj_valid = 1'b1;
        inj_addr  = a;
        inj_mask  = m;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(scrub_busy), 0);
        chk("rst_corr", int'(cnt_corr), 0);
        chk("rst_uncorr", int'(cnt_uncorr), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        do_reset();
        chk("ready_after_reset", int'(req_ready), 1);

        // Clean write/read of every address.
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 4'(a));
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 4'(a), 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("s1_corr", int'(cnt_corr), 0);
        chk("s1_uncorr", int'(cnt_uncorr), 0);

        // Single-bit error on d0 corrected and written back.
        do_reset();
        wr(4'd3, 4'b1010);
        inject(4'd3, 8'h04);
        rd(4'd3, 4'b1010, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("s2_corr", int'(cnt_corr), 1);
        rd(4'd3, 4'b1010, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("s2_corr_again", int'(cnt_corr), 1);

        // Parity-only error, then a double error (raw data 6 with d0 flipped = 7).
        do_reset();
        wr(4'd5, 4'h5);
        wr(4'd6, 4'h6);
        inject(4'd5, 8'h80);
        rd(4'd5, 4'h5, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("s3_corr", int'(cnt_corr), 1);
        rd(4'd5, 4'h5, 1'b0, 1'b0, 1'b0);
        inject(4'd6, 8'h0C);
        rd(4'd6, 4'h7, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("s3_uncorr", int'(cnt_uncorr), 1);
        rd(4'd6, 4'h7, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("s3_uncorr_again", int'(cnt_uncorr), 2);
        chk("s3_corr_final", int'(cnt_corr), 1);

        // Background scrub repairs addr 0 and 1, then addr 2 on the next pass.
        do_reset();
        pulses = 0;
        inject(4'd0, 8'h01);
        inject(4'd1, 8'h01);
        repeat (2 * SI + 8) @(negedge clk);
        chk("s4_corr", int'(cnt_corr), 2);
        chk("s4_pulses", pulses, 2);
        @(posedge clk);
        #1;
        rd(4'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        rd(4'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("s4_corr_after_rd", int'(cnt_corr), 2);
        inject(4'd2, 8'h01);
        repeat (SI) @(negedge clk);
        chk("s4_ptr_advanced", int'(cnt_corr), 3);
        @(posedge clk);
        #1;

        // Continuous host reads must not starve the scrubber.
        do_reset();
        pulses = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 25; k++) rd(4'(k), 4'h0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("s5_pulses", pulses, 1);

        // Response held stable while host stalls.
        rsp_ready = 1'b0;
        rd(4'd9, 4'h0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) tmo("s5_valid");
        repeat (5) @(negedge clk);
        chk("s5_held_valid", int'(rsp_valid), 1);
        chk("s5_ready_low", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while a response is outstanding.
        do_reset();
        @(posedge clk);
        #1;
        wr(4'd2, 4'hB);
        rsp_ready = 1'b0;
        rd(4'd2, 4'hB, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) tmo("s6_valid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s6_valid_in_reset", int'(rsp_valid), 0);
        chk("s6_ready_in_reset", int'(req_ready), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        rd(4'd2, 4'h0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("s6_corr", int'(cnt_corr), 0);
        chk("s6_uncorr", int'(cnt_uncorr), 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
